// File: rtl/mac_result_writer_if.sv
//------------------------------------------------------------------------------
// mac_result_writer_if
// Bundles the MAC result stream (with its stall back-channel) and the output
// memory write port used by mac_result_writer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mac_result_writer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CH_WIDTH   = 32,
   parameter int ADDR_WIDTH = 16
);
   // MAC result stream
   logic                  res_valid;
   logic [DATA_WIDTH-1:0] res_data;
   logic [CH_WIDTH-1:0]   res_ch;
   logic                  res_final;
   logic                  stall;

   // memory write port
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ready;

   // environment side: MAC feeder plus output memory
   modport master (
      output res_valid, res_data, res_ch, res_final, mem_ready,
      input  stall, mem_we, mem_addr, mem_wdata
   );

   // writer side
   modport slave (
      input  res_valid, res_data, res_ch, res_final, mem_ready,
      output stall, mem_we, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/mac_result_writer.sv
//------------------------------------------------------------------------------
// mac_result_writer
// Consumer end of the MAC output: buffers final accumulator results in a small
// FIFO, writes them to output memory with generated addresses, and raises a
// stall early enough that results already inside the MAC pipeline still fit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_result_writer #(
   parameter int DATA_WIDTH = 16,
   parameter int CH_WIDTH   = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int PIPE_SLACK = 4
) (
   input  wire logic                  clk,
   input  wire logic                  arst_n_in,
   input  wire logic                  start,
   input  wire logic                  flush,
   input  wire logic [ADDR_WIDTH-1:0] base_addr,
   input  wire logic [ADDR_WIDTH-1:0] ch_stride,
   input  wire logic [CH_WIDTH-1:0]   num_ch,
   mac_result_writer_if.slave         bus,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow,
   output logic [15:0]                words_written
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_LVL  = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] STALL_LVL = (PTR_W+1)'(FIFO_DEPTH - PIPE_SLACK);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // layer context captured on start
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] stride_q;
   logic [CH_WIDTH-1:0]   last_ch;
   logic [ADDR_WIDTH-1:0] pixel_idx;

   // result FIFO
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [CH_WIDTH-1:0]   fifo_ch   [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        count;

   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push_req;
   logic                  push_ok;
   logic                  drop;
   logic                  pop;
   logic                  start_acc;
   logic [DATA_WIDTH-1:0] head_data;
   logic [CH_WIDTH-1:0]   head_ch;
   logic [ADDR_WIDTH-1:0] head_ch_addr;
   logic [ADDR_WIDTH-1:0] addr_calc;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_LVL);
   assign start_acc  = (state == ST_IDLE) && start;

   // partial sums and anything seen while idle never enter the buffer
   assign push_req   = (state != ST_IDLE) && bus.res_valid && bus.res_final;
   // a full buffer still accepts a result if the head leaves in the same cycle
   assign push_ok    = push_req && (!fifo_full || pop);
   assign drop       = push_req && fifo_full && !pop;
   assign pop        = bus.mem_we && bus.mem_ready;

   assign head_data  = fifo_data[rd_ptr];
   assign head_ch    = fifo_ch[rd_ptr];

   // channel tag reduced to address width before the stride multiply
   generate
      if (CH_WIDTH >= ADDR_WIDTH) begin : g_ch_trunc
         assign head_ch_addr = head_ch[ADDR_WIDTH-1:0];
      end else begin : g_ch_extend
         assign head_ch_addr = {{(ADDR_WIDTH-CH_WIDTH){1'b0}}, head_ch};
      end
   endgenerate

   // address wraps naturally at ADDR_WIDTH bits
   assign addr_calc     = base_q + head_ch_addr * stride_q + pixel_idx;

   assign bus.mem_we    = !fifo_empty;
   assign bus.mem_addr  = bus.mem_we ? addr_calc : '0;
   assign bus.mem_wdata = bus.mem_we ? head_data : '0;
   assign bus.stall     = (state != ST_IDLE) && (count >= STALL_LVL);
   assign busy          = (state != ST_IDLE);

   // FIFO storage; contents are don't-care until pointed at by a valid count
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_data[wr_ptr] <= bus.res_data;
         fifo_ch[wr_ptr]   <= bus.res_ch;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // layer context, pixel walk, write counter and sticky overflow
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         base_q        <= '0;
         stride_q      <= '0;
         last_ch       <= '0;
         pixel_idx     <= '0;
         words_written <= '0;
         overflow      <= 1'b0;
      end else if (start_acc) begin
         base_q        <= base_addr;
         stride_q      <= ch_stride;
         last_ch       <= num_ch - CH_WIDTH'(1);
         pixel_idx     <= '0;
         words_written <= '0;
         overflow      <= 1'b0;
      end else begin
         if (pop) begin
            if (words_written != 16'hFFFF) begin
               words_written <= words_written + 16'd1;
            end
            // last channel of a pixel written: move on to the next pixel
            if (head_ch == last_ch) begin
               pixel_idx <= pixel_idx + ADDR_WIDTH'(1);
            end
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // state register
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and completion pulse; a result arriving on the last drain
   // cycle holds the block in DRAIN so it is not stranded in IDLE
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty && !push_req) begin
               state_nxt = ST_IDLE;
               done      = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mac_result_writer.sv
//------------------------------------------------------------------------------
// tb_mac_result_writer
// Directed scenarios plus randomized layers, all checked every cycle against a
// queue-based reference model of the writer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_result_writer;

   localparam int DW    = 16;
   localparam int CW    = 32;
   localparam int AW    = 16;
   localparam int DEPTH = 8;
   localparam int SLACK = 4;

   logic          clk = 1'b0;
   logic          arst_n_in;
   logic          start;
   logic          flush;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] ch_stride;
   logic [CW-1:0] num_ch;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [15:0]   words_written;

   always #5 clk = ~clk;

   mac_result_writer_if #(.DATA_WIDTH(DW), .CH_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

   mac_result_writer #(
      .DATA_WIDTH (DW),
      .CH_WIDTH   (CW),
      .ADDR_WIDTH (AW),
      .FIFO_DEPTH (DEPTH),
      .PIPE_SLACK (SLACK)
   ) dut (
      .clk           (clk),
      .arst_n_in     (arst_n_in),
      .start         (start),
      .flush         (flush),
      .base_addr     (base_addr),
      .ch_stride     (ch_stride),
      .num_ch        (num_ch),
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow),
      .words_written (words_written)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: 0 idle, 1 run, 2 drain
   typedef struct {
      logic [15:0] d;
      logic [31:0] ch;
   } entry_t;

   entry_t      q[$];
   int          m_state;
   int unsigned m_base, m_stride, m_num_ch, m_pix, m_ww;
   bit          m_ovf;

   logic [15:0] wr_addr[$];
   logic [15:0] wr_data[$];
   int          done_seen;

   function automatic logic [15:0] model_addr(entry_t e);
      logic [31:0] t;
      t = m_base + (e.ch & 32'hFFFF) * m_stride + m_pix;
      return t[15:0];
   endfunction

   task automatic model_reset();
      q.delete();
      m_state = 0;
      m_pix   = 0;
      m_ww    = 0;
      m_ovf   = 0;
   endtask

   // check all outputs at the falling edge, then advance the model across the rising edge
   task automatic tick();
      bit push, pop, was_full, was_empty, exp_done;
      logic [15:0] e_addr, e_data;
      @(negedge clk);
      push      = (m_state != 0) && bus.res_valid && bus.res_final;
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      exp_done  = (m_state == 2) && was_empty && !push;
      e_addr    = 16'h0;
      e_data    = 16'h0;
      if (!was_empty) begin
         e_addr = model_addr(q[0]);
         e_data = q[0].d;
      end
      check("mem_we", bus.mem_we, !was_empty);
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_wdata", bus.mem_wdata, e_data);
      check("stall", bus.stall, (m_state != 0) && (q.size() >= DEPTH - SLACK));
      check("busy", busy, m_state != 0);
      check("done", done, exp_done);
      check("overflow", overflow, m_ovf);
      check("words_written", words_written, m_ww);
      if (done) done_seen++;
      pop = !was_empty && bus.mem_ready;
      if (bus.mem_we && bus.mem_ready) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
      end
      @(posedge clk);
      if (!arst_n_in) begin
         model_reset();
      end else if (m_state == 0 && start) begin
         m_base   = base_addr;
         m_stride = ch_stride;
         m_num_ch = num_ch;
         m_pix    = 0;
         m_ww     = 0;
         m_ovf    = 0;
         m_state  = 1;
      end else begin
         if (pop) begin
            if (q[0].ch == m_num_ch - 1) m_pix = (m_pix + 1) & 32'hFFFF;
            if (m_ww < 32'hFFFF) m_ww++;
            void'(q.pop_front());
         end
         if (push) begin
            if (was_full && !pop) m_ovf = 1;
            else q.push_back('{bus.res_data, bus.res_ch});
         end
         if (m_state == 1 && flush) m_state = 2;
         else if (m_state == 2 && was_empty && !push) m_state = 0;
      end
      #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic push1(input logic [15:0] d, input logic [31:0] ch);
      bus.res_valid = 1'b1;
      bus.res_final = 1'b1;
      bus.res_data  = d;
      bus.res_ch    = ch;
      tick();
      bus.res_valid = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] b, input logic [15:0] s, input logic [31:0] n);
      base_addr = b;
      ch_stride = s;
      num_ch    = n;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_empty(input int max_cycles);
      for (int i = 0; i < max_cycles && q.size() != 0; i++) tick();
      check("drain_bound", bus.mem_we, 1'b0);
   endtask

   task automatic wait_idle(input int max_cycles);
      for (int i = 0; i < max_cycles && m_state != 0; i++) tick();
      check("idle_bound", busy, 1'b0);
   endtask

   initial begin
      arst_n_in     = 1'b0;
      start         = 1'b0;
      flush         = 1'b0;
      base_addr     = '0;
      ch_stride     = '0;
      num_ch        = 32'd1;
      bus.res_valid = 1'b0;
      bus.res_final = 1'b0;
      bus.res_data  = '0;
      bus.res_ch    = '0;
      bus.mem_ready = 1'b0;
      done_seen     = 0;
      model_reset();
      m_base = 0; m_stride = 0; m_num_ch = 1;

      // reset state
      tick();
      tick();
      arst_n_in = 1'b1;
      tick();

      // basic addressing across a pixel boundary
      bus.mem_ready = 1'b1;
      do_start(16'h0100, 16'h0010, 32'd2);
      clear_log();
      push1(16'd5, 32'd0);
      push1(16'd7, 32'd1);
      push1(16'd9, 32'd0);
      wait_empty(20);
      check("s1_nwr", wr_addr.size(), 3);
      if (wr_addr.size() == 3) begin
         check("s1_addr0", wr_addr[0], 16'h0100);
         check("s1_data0", wr_data[0], 16'd5);
         check("s1_addr1", wr_addr[1], 16'h0110);
         check("s1_data1", wr_data[1], 16'd7);
         check("s1_addr2", wr_addr[2], 16'h0101);
         check("s1_data2", wr_data[2], 16'd9);
      end
      check("s1_words", words_written, 16'd3);

      // partial sums are discarded
      clear_log();
      bus.res_valid = 1'b1;
      bus.res_final = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.res_data = 16'($urandom);
         bus.res_ch   = 32'(i & 1);
         tick();
      end
      push1(16'hFFFD, 32'd0);
      wait_empty(20);
      check("s2_nwr", wr_addr.size(), 1);
      if (wr_addr.size() == 1) begin
         check("s2_data", wr_data[0], 16'hFFFD);
         check("s2_addr", wr_addr[0], 16'h0101);
      end

      // back-pressure: stall at threshold, head held stable
      clear_log();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) push1(16'(11 + i), 32'((i + 1) & 1));
      check("s3_stall_hi", bus.stall, 1'b1);
      repeat (3) tick();
      bus.mem_ready = 1'b1;
      wait_empty(20);
      check("s3_nwr", wr_addr.size(), 4);
      if (wr_addr.size() == 4) begin
         check("s3_addr0", wr_addr[0], 16'h0111);
         for (int i = 0; i < 4; i++) check("s3_order", wr_data[i], 16'(11 + i));
      end
      check("s3_stall_lo", bus.stall, 1'b0);

      // overflow, then push and pop together at full
      clear_log();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 9; i++) push1(16'(100 + i), 32'd0);
      check("s4_ovf", overflow, 1'b1);
      bus.mem_ready = 1'b1;
      push1(16'd200, 32'd0);
      wait_empty(30);
      check("s4_nwr", wr_addr.size(), 9);
      if (wr_addr.size() == 9) begin
         check("s4_first", wr_data[0], 16'd100);
         check("s4_last", wr_data[8], 16'd200);
      end

      // flush and drain
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) push1(16'(300 + i), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("s5_busy", busy, 1'b1);
      done_seen     = 0;
      bus.mem_ready = 1'b1;
      wait_idle(50);
      repeat (2) tick();
      check("s5_done_once", done_seen, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check("s5_flush_idle", busy, 1'b0);

      // randomized layers
      for (int l = 0; l < 6; l++) begin
         do_start(16'($urandom), 16'($urandom_range(0, 64)),
                  (l % 3 == 2) ? 32'($urandom_range(1, 8)) : 32'($urandom_range(1, 3)));
         for (int c = 0; c < 150; c++) begin
            bus.res_valid = ($urandom_range(0, 2) != 0) && (!bus.stall || $urandom_range(0, 9) == 0);
            bus.res_final = ($urandom_range(0, 4) != 0);
            bus.res_data  = 16'($urandom);
            bus.res_ch    = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, m_num_ch - 1));
            bus.mem_ready = ($urandom_range(0, 9) < 6);
            start         = ($urandom_range(0, 40) == 0);
            tick();
         end
         bus.res_valid = 1'b0;
         start         = 1'b0;
         flush         = 1'b1;
         tick();
         flush         = 1'b0;
         bus.mem_ready = 1'b1;
         wait_idle(100);
      end

      // asynchronous reset in the middle of a drain
      do_start(16'h0200, 16'h0004, 32'd1);
      bus.mem_ready = 1'b0;
      push1(16'd55, 32'd0);
      push1(16'd66, 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #2;
      arst_n_in = 1'b0;
      #1;
      model_reset();
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_words", words_written, 16'd0);
      tick();
      arst_n_in     = 1'b1;
      bus.mem_ready = 1'b1;
      clear_log();
      repeat (4) tick();
      check("rst_no_write", wr_addr.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
